// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter, LSB first, registered outputs.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk_100MHz,
  input  logic                 rst,
  input  logic                 Tx_start,
  input  logic [DATA_BITS-1:0] Din,
  output logic                 Tx,
  output logic                 Tx_busy,
  output logic                 Tx_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state;
  logic [BW-1:0]        baud_cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 baud_end;
`ifdef UART_TX_PARITY_EN
  logic                 parity;
`endif

  assign baud_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk_100MHz or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      Tx        <= 1'b1;
      Tx_busy   <= 1'b0;
      Tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      Tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          Tx       <= 1'b1;
          Tx_busy  <= 1'b0;
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (Tx_start) begin
            shift_reg <= Din;
`ifdef UART_TX_PARITY_EN
            parity    <= ^Din;
`endif
            Tx        <= 1'b0;
            Tx_busy   <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            Tx       <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              Tx    <= parity;
              state <= PARITY;
`else
              Tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              Tx        <= shift_reg[1];
              shift_reg <= shift_reg >> 1;
              bit_idx   <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_end) begin
            baud_cnt <= '0;
            Tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        // Leave one cycle early: the done cycle is the stop bit's last
        // cycle, so a start accepted there follows with no idle gap.
        STOP: begin
          if (baud_cnt == STOP_LAST) begin
            baud_cnt <= '0;
            Tx_busy  <= 1'b0;
            Tx_done  <= 1'b1;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serial UART transmitter. It takes a parallel byte plus a start strobe and drives an 8N1 frame, LSB first, on the Tx line.
- It sits directly upstream of Receiver: Tx connects to Receiver.Rx in the loopback build and on-board.
- It runs from the same 100 MHz system clock at the same 9600 baud default, so frames are bit-compatible with Receiver.

Parameters:
- CLKS_PER_BIT, 10416, clock cycles per serial bit (100 MHz / 9600).
- DATA_BITS, 8, data bits per frame (LSB first).

Ports:
- clk_100MHz  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- Tx_start  input  1  request to send Din; sampled on rising edge.
- Din  input  DATA_BITS  byte to send; latched when Tx_start is accepted.
- Tx  output  1  serial line; idle high.
- Tx_busy  output  1  high while a frame is in progress.
- Tx_done  output  1  one-cycle pulse when the stop bit completes.

Behaviour:
- Reset (rst low, async): Tx=1, Tx_busy=0, Tx_done=0, state=IDLE, bit counter=0, baud counter=0, shift register=0. Takes effect mid-frame too; the line returns high immediately.
- All outputs are registered. FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - Tx=1, Tx_busy=0.
  - If Tx_start=1 at edge k: latch Din into the shift register, go to START, Tx_busy=1. Tx goes low at edge k+1.
- START: Tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - Tx = shift_reg[0] for CLKS_PER_BIT cycles, then shift right and increment the bit index.
  - After bit DATA_BITS-1 completes, go to STOP.
- STOP:
  - Tx=1 for CLKS_PER_BIT cycles.
  - Then go to IDLE: Tx_done=1 for exactly one cycle and Tx_busy=0 on that same cycle.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. Width is $clog2(CLKS_PER_BIT).
- Frame length is exactly (2+DATA_BITS)*CLKS_PER_BIT cycles (10416*10 = 104160 cycles by default).
- Back-to-back: Tx_start may be high on the Tx_done cycle. It is accepted because the FSM is in IDLE, and the next start bit begins the following cycle. No extra idle bits are inserted.
- Tx_start while Tx_busy=1 is ignored; it is not queued. Din changes after acceptance do not affect the frame in flight.
- Tx_start held high continuously sends Din repeatedly, re-latching Din at each acceptance.
- Tx never glitches: it changes only on bit boundaries.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined:
  - a PARITY state is inserted between DATA and STOP;
  - Tx = even parity (XOR of the latched byte) for CLKS_PER_BIT cycles;
  - frame length becomes (3+DATA_BITS)*CLKS_PER_BIT.
- When undefined: 8N1 only; no PARITY state or logic is synthesised.

Test Plan:
- Reset: CLKS_PER_BIT=16; hold rst=0 for 3 cycles -> Tx=1, Tx_busy=0, Tx_done=0. Assert rst=0 mid-DATA -> Tx=1 and Tx_busy=0 asynchronously. After release, the next Tx_start sends a clean frame.
- Single byte: Din=8'h77, one-cycle Tx_start -> Tx sequence 0,1,1,1,0,1,1,1,0,1, each bit exactly 16 cycles. Tx_done pulses once, 160 cycles after the first low cycle.
- Back-to-back: 8'h77, then Tx_start on the Tx_done cycle with Din=8'h75 -> second start bit immediately follows the first stop bit. Data bits 1,0,1,0,1,1,1,0. Two Tx_done pulses, 160 cycles apart.
- Busy rejection: pulse Tx_start with Din=8'hFF during the 8'h77 frame -> frame unchanged, exactly one Tx_done, Tx stays high afterwards.
- Loopback: default CLKS_PER_BIT=10416, Tx wired to Receiver.Rx; send 8'h77 then 8'h75 -> Receiver Dout=8'h77 then 8'h75, one Rx_done per byte.
- Parity (UART_TX_PARITY_EN defined): Din=8'h75 (five ones) -> parity bit 1 before stop; Din=8'h77 (six ones) -> parity bit 0; frame length 176 cycles at CLKS_PER_BIT=16.
